// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants, types and immediate decoders for the instruction fetch queue.
package inst_fetch_queue_pkg;

  localparam int unsigned DEPTH_DEFAULT     = 16;
  localparam int unsigned BHT_IDX_W_DEFAULT = 8;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StDrain
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_jump;
    logic [31:0] pred_pc;
  } fq_entry_t;

  // J-type immediate, sign-extended.
  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // B-type immediate, sign-extended.
  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetch_queue_next_pc_predict.sv
// Static/BHT next-PC prediction for one returned instruction.
module next_pc_predict
  import inst_fetch_queue_pkg::*;
(
  input  logic [31:0] req_pc_i,
  input  logic [31:0] inst_i,
  input  logic        bht_taken_i,
  output logic        pred_jump_o,
  output logic [31:0] target_o
);

  // Decode opcode; JALR has no target available here so it falls through.
  always_comb begin
    pred_jump_o = 1'b0;
    target_o    = req_pc_i + 32'd4;
    unique case (inst_i[6:0])
      OPC_JAL: begin
        pred_jump_o = 1'b1;
        target_o    = req_pc_i + imm_j(inst_i);
      end
      OPC_BRANCH: begin
        pred_jump_o = bht_taken_i;
        if (bht_taken_i) target_o = req_pc_i + imm_b(inst_i);
      end
      OPC_JALR: begin
        pred_jump_o = 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Single-outstanding instruction fetcher with next-PC prediction and an in-order FIFO.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEFAULT,
  parameter int unsigned BHT_IDX_W = BHT_IDX_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush_i,
  input  logic [31:0]                flush_pc_i,
  output logic                       fetch_valid_o,
  output logic [31:0]                fetch_pc_o,
  input  logic                       fetch_ready_i,
  input  logic                       resp_valid_i,
  input  logic [31:0]                resp_inst_i,
  output logic [BHT_IDX_W-1:0]       bht_idx_o,
  input  logic                       bht_taken_i,
  output logic                       deq_valid_o,
  input  logic                       deq_ready_i,
  output logic [31:0]                deq_pc_o,
  output logic [31:0]                deq_inst_o,
  output logic [31:0]                deq_pred_pc_o,
  output logic                       deq_pred_jump_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  fetch_state_e    state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  fq_entry_t       mem_q [DEPTH];

  logic        push, pop, handshake;
  logic        pred_jump;
  logic [31:0] target;
  fq_entry_t   push_entry, head_entry;

  next_pc_predict u_predict (
    .req_pc_i    (req_pc_q),
    .inst_i      (resp_inst_i),
    .bht_taken_i (bht_taken_i),
    .pred_jump_o (pred_jump),
    .target_o    (target)
  );

  assign push_entry = '{pc: req_pc_q, inst: resp_inst_i, pred_jump: pred_jump, pred_pc: target};
  assign head_entry = mem_q[head_q];

  assign fetch_pc_o      = pc_q;
  assign bht_idx_o       = req_pc_q[BHT_IDX_W+1:2];
  assign count_o         = count_q;
  assign deq_pc_o        = head_entry.pc;
  assign deq_inst_o      = head_entry.inst;
  assign deq_pred_jump_o = head_entry.pred_jump;
  assign deq_pred_pc_o   = head_entry.pred_pc;

  // Next-state: flush overrides push/pop/handshake; rdy gating happens in the register.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    push          = 1'b0;
    pop           = 1'b0;
    fetch_valid_o = rdy && (state_q == StReq) && (count_q != Full);
    deq_valid_o   = rdy && (count_q != '0);
    handshake     = fetch_valid_o && fetch_ready_i;

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = flush_pc_i;
      // A response landing in the flush cycle itself closes out the outstanding fetch.
      if (state_q != StReq) state_d = resp_valid_i ? StReq : StDrain;
    end else begin
      pop = deq_valid_o && deq_ready_i;
      unique case (state_q)
        StReq: begin
          if (handshake) begin
            req_pc_d = pc_q;
            state_d  = StWait;
          end
        end
        StWait: begin
          if (resp_valid_i) begin
            push    = 1'b1;
            pc_d    = target;
            state_d = StReq;
          end
        end
        StDrain: begin
          if (resp_valid_i) state_d = StReq;
        end
        default: state_d = StReq;
      endcase
      head_d  = head_q + PtrW'(pop);
      tail_d  = tail_q + PtrW'(push);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // State and FIFO storage; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StReq;
      pc_q     <= '0;
      req_pc_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (rdy) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      if (push) mem_q[tail_q] <= push_entry;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed plus random bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, rdy, flush_i, fetch_ready_i, resp_valid_i, bht_taken_i, deq_ready_i;
  logic [31:0] flush_pc_i, resp_inst_i;
  logic        fetch_valid_o, deq_valid_o, deq_pred_jump_o;
  logic [31:0] fetch_pc_o, deq_pc_o, deq_inst_o, deq_pred_pc_o;
  logic [7:0]  bht_idx_o;
  logic [4:0]  count_o;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(16), .BHT_IDX_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .fetch_valid_o   (fetch_valid_o),
    .fetch_pc_o      (fetch_pc_o),
    .fetch_ready_i   (fetch_ready_i),
    .resp_valid_i    (resp_valid_i),
    .resp_inst_i     (resp_inst_i),
    .bht_idx_o       (bht_idx_o),
    .bht_taken_i     (bht_taken_i),
    .deq_valid_o     (deq_valid_o),
    .deq_ready_i     (deq_ready_i),
    .deq_pc_o        (deq_pc_o),
    .deq_inst_o      (deq_inst_o),
    .deq_pred_pc_o   (deq_pred_pc_o),
    .deq_pred_jump_o (deq_pred_jump_o),
    .count_o         (count_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pj;
    logic [31:0] ppc;
  } ent_t;

  int          vectors = 0;
  int          miscompares = 0;
  ent_t        q[$];
  logic [31:0] m_pc, m_req_pc;
  int          m_st;      // 0 ready to request, 1 awaiting response, 2 dropping stale response
  bit          mem_pend;  // memory has accepted a request and not yet returned it

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // kind: 1 JAL, 2 conditional branch, 3 JALR, otherwise OP-IMM.
  function automatic logic [31:0] mk_inst(input int kind, input logic [31:0] off,
                                          input logic [31:0] fill);
    logic [31:0] i;
    case (kind)
      1:       i = {off[20], off[10:1], off[11], off[19:12], fill[11:7], 7'b1101111};
      2:       i = {off[12], off[10:5], fill[24:12], off[4:1], off[11], 7'b1100011};
      3:       i = {fill[31:7], 7'b1100111};
      default: i = {fill[31:7], 7'b0010011};
    endcase
    return i;
  endfunction

  // One clock: drive at negedge, check outputs, advance model, return just after posedge.
  task automatic cyc(input bit rs, input bit r, input bit fl, input logic [31:0] fpc,
                     input bit frdy, input bit drdy, input bit rsp, input int kind,
                     input logic [31:0] off, input bit tk);
    bit   deliv, hs, exp_fv;
    ent_t e;
    @(negedge clk);
    rst           = rs;
    rdy           = r;
    flush_i       = fl;
    flush_pc_i    = fpc;
    fetch_ready_i = frdy && !mem_pend && !rs;
    deq_ready_i   = drdy;
    resp_valid_i  = rsp && mem_pend && !rs;
    resp_inst_i   = mk_inst(kind, off, $urandom);
    bht_taken_i   = tk;
    #1;
    exp_fv = r && (m_st == 0) && (q.size() < DEPTH);
    if (!rs) begin
      chk("fetch_valid", {31'd0, fetch_valid_o}, {31'd0, exp_fv});
      chk("fetch_pc", fetch_pc_o, m_pc);
      chk("count", {27'd0, count_o}, q.size());
      chk("deq_valid", {31'd0, deq_valid_o}, {31'd0, (r && q.size() > 0)});
      if (q.size() > 0) begin
        chk("deq_pc", deq_pc_o, q[0].pc);
        chk("deq_inst", deq_inst_o, q[0].inst);
        chk("deq_pred_jump", {31'd0, deq_pred_jump_o}, {31'd0, q[0].pj});
        chk("deq_pred_pc", deq_pred_pc_o, q[0].ppc);
      end
      if (m_st != 0) chk("bht_idx", {24'd0, bht_idx_o}, {24'd0, m_req_pc[9:2]});
    end
    deliv = resp_valid_i && r;
    hs    = fetch_ready_i && exp_fv;
    if (rs) begin
      q.delete();
      m_pc     = 32'd0;
      m_req_pc = 32'd0;
      m_st     = 0;
    end else if (r) begin
      if (fl) begin
        q.delete();
        m_pc = fpc;
        if (m_st != 0) m_st = deliv ? 0 : 2;
      end else begin
        if (q.size() > 0 && drdy) void'(q.pop_front());
        case (m_st)
          0: if (hs) begin
            m_req_pc = m_pc;
            m_st     = 1;
          end
          1: if (deliv) begin
            e.pc   = m_req_pc;
            e.inst = resp_inst_i;
            e.pj   = (kind == 1) || (kind == 2 && tk);
            e.ppc  = e.pj ? m_req_pc + off : m_req_pc + 32'd4;
            q.push_back(e);
            m_pc = e.ppc;
            m_st = 0;
          end
          default: if (deliv) m_st = 0;
        endcase
      end
    end
    if (hs) mem_pend = 1'b1;
    if (deliv) mem_pend = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_one(input int kind, input logic [31:0] off, input bit tk, input bit drdy);
    cyc(0, 1, 0, 0, 1, drdy, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, drdy, 1, kind, off, tk);
  endtask

  initial begin
    logic [31:0] o;
    int          k;
    rst = 1'b1; rdy = 1'b1; flush_i = 1'b0; flush_pc_i = '0; fetch_ready_i = 1'b0;
    resp_valid_i = 1'b0; resp_inst_i = '0; bht_taken_i = 1'b0; deq_ready_i = 1'b0;
    mem_pend = 1'b0; m_pc = '0; m_req_pc = '0; m_st = 0;

    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_fetch_valid", {31'd0, fetch_valid_o}, 32'd1);
    chk("rst_fetch_pc", fetch_pc_o, 32'd0);
    chk("rst_deq_pc", deq_pc_o, 32'd0);
    chk("rst_deq_inst", deq_inst_o, 32'd0);
    chk("rst_deq_pred_pc", deq_pred_pc_o, 32'd0);
    chk("rst_count", {27'd0, count_o}, 32'd0);

    // Sequential OP-IMM at 0, 4, 8, 0xc.
    for (int i = 0; i < 3; i++) fetch_one(0, 0, 0, 0);
    chk("seq_fetch_pc", fetch_pc_o, 32'hc);
    chk("seq_head_pc", deq_pc_o, 32'h0);
    chk("seq_head_pred_pc", deq_pred_pc_o, 32'h4);
    fetch_one(0, 0, 0, 0);

    // JAL at 0x10, +0x20.
    fetch_one(1, 32'h20, 0, 0);
    chk("jal_next_pc", fetch_pc_o, 32'h30);
    for (int i = 0; i < 4; i++) fetch_one(0, 0, 0, 0);

    // BEQ at 0x40, -8: taken then not taken.
    fetch_one(2, 32'hffff_fff8, 1, 0);
    chk("beq_taken_pc", fetch_pc_o, 32'h38);
    fetch_one(0, 0, 0, 0);
    fetch_one(0, 0, 0, 0);
    fetch_one(2, 32'hffff_fff8, 0, 0);
    chk("beq_nt_pc", fetch_pc_o, 32'h44);

    // Fill to DEPTH, then pop one and push/pop together.
    for (int i = 0; i < 3; i++) fetch_one(0, 0, 0, 0);
    chk("full_count", {27'd0, count_o}, 32'd16);
    chk("full_no_fetch", {31'd0, fetch_valid_o}, 32'd0);
    cyc(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    chk("pop_count", {27'd0, count_o}, 32'd15);
    chk("pop_refetch", {31'd0, fetch_valid_o}, 32'd1);
    cyc(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 1, 1, 0, 0, 0);
    chk("push_pop_count", {27'd0, count_o}, 32'd15);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("drained_count", {27'd0, count_o}, 32'd0);

    // Flush while awaiting a response.
    fetch_one(0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("flush_count", {27'd0, count_o}, 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("flush_dropped", {27'd0, count_o}, 32'd0);
    chk("flush_pc", fetch_pc_o, 32'h100);
    chk("flush_refetch", {31'd0, fetch_valid_o}, 32'd1);

    // rdy low for 3 cycles mid-wait, response re-presented afterwards.
    cyc(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 1, 0, 0, 0);
    chk("stall_count", {27'd0, count_o}, 32'd1);
    chk("stall_head_pc", deq_pc_o, 32'h100);

    // Reset mid-wait: the late response must be ignored.
    cyc(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("rst_wait_count", {27'd0, count_o}, 32'd0);
    chk("rst_wait_pc", fetch_pc_o, 32'd0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      k = $urandom_range(0, 3);
      o = $urandom;
      o[0] = 1'b0;
      if (k == 1) o = {{11{o[20]}}, o[20:0]};
      else        o = {{19{o[12]}}, o[12:0]};
      flush_pc_i = $urandom;
      flush_pc_i[1:0] = 2'b00;
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 29) == 0), flush_pc_i, $urandom_range(0, 1) == 1,
          ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, k, o,
          $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
